// File: rtl/dmem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the data memory.
//   c_*   : core load/store request, grant back
//   a_*   : auxiliary (debug/DMA) request, grant back
//   rsp_* : registered response to the winning requester
//   m_*   : single-port data memory interface
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 11
);
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdata;
  logic [2:0]        c_func3;
  logic              c_gnt;

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [31:0]       a_wdata;
  logic [2:0]        a_func3;
  logic              a_gnt;

  logic              rsp_valid;
  logic              rsp_id;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [2:0]        m_func3;
  logic              m_rd_en;
  logic              m_wr_en;
  logic [31:0]       m_rdata;

  // Requesters and memory side
  modport master (
    output c_req, c_we, c_addr, c_wdata, c_func3,
    output a_req, a_we, a_addr, a_wdata, a_func3,
    output m_rdata,
    input  c_gnt, a_gnt,
    input  rsp_valid, rsp_id, rsp_rdata, rsp_err,
    input  m_addr, m_wdata, m_func3, m_rd_en, m_wr_en
  );

  // Arbiter side
  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_func3,
    input  a_req, a_we, a_addr, a_wdata, a_func3,
    input  m_rdata,
    output c_gnt, a_gnt,
    output rsp_valid, rsp_id, rsp_rdata, rsp_err,
    output m_addr, m_wdata, m_func3, m_rd_en, m_wr_en
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer in front of the byte-addressed data memory.
// Core has priority; aux is forced through after STARVE_LIMIT consecutive core
// grants while it waits. Each access is alignment/func3 checked, drives the
// memory for one cycle, and returns a registered response pulse.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request/grant for core and aux, response, memory port
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  starve_cnt, starve_cnt_nxt;

  logic              lat_we;
  logic              lat_id;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [2:0]        lat_func3;

  logic              rsp_valid, rsp_id, rsp_err;
  logic [31:0]       rsp_rdata;

  logic              any_req_c, aux_wins_c, legal_c;
  logic              c_gnt_c, a_gnt_c, m_rd_en_c, m_wr_en_c;

  // Legal func3 for the direction, with natural alignment
  function automatic logic is_legal(input logic we, input logic [1:0] a,
                                    input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = !a[0];
      3'b010:  ok = (a == 2'b00);
      3'b100:  ok = !we;
      3'b101:  ok = !we && !a[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign any_req_c  = bus.c_req || bus.a_req;
  assign aux_wins_c = bus.a_req &&
                      (!bus.c_req || (starve_cnt == CNT_W'(STARVE_LIMIT)));
  assign legal_c    = is_legal(lat_we, lat_addr[1:0], lat_func3);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  // Next state, grants, memory enables, starvation count
  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    c_gnt_c        = 1'b0;
    a_gnt_c        = 1'b0;
    m_rd_en_c      = 1'b0;
    m_wr_en_c      = 1'b0;
    case (state)
      IDLE: begin
        if (any_req_c && !rst) begin
          a_gnt_c   = aux_wins_c;
          c_gnt_c   = !aux_wins_c;
          state_nxt = ACCESS;
          if (!aux_wins_c && bus.a_req) begin
            if (starve_cnt != CNT_W'(STARVE_LIMIT))
              starve_cnt_nxt = starve_cnt + CNT_W'(1);
          end else begin
            starve_cnt_nxt = '0;
          end
        end
      end
      ACCESS: begin
        state_nxt = IDLE;
        // Reset gating keeps a dropped transaction from writing
        if (legal_c && !rst) begin
          m_rd_en_c = !lat_we;
          m_wr_en_c = lat_we;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the winning request on the grant edge
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_id    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_func3 <= '0;
    end else if (state == IDLE && any_req_c) begin
      if (aux_wins_c) begin
        lat_we    <= bus.a_we;
        lat_id    <= 1'b1;
        lat_addr  <= bus.a_addr;
        lat_wdata <= bus.a_wdata;
        lat_func3 <= bus.a_func3;
      end else begin
        lat_we    <= bus.c_we;
        lat_id    <= 1'b0;
        lat_addr  <= bus.c_addr;
        lat_wdata <= bus.c_wdata;
        lat_func3 <= bus.c_func3;
      end
    end
  end

  // Response pulse on the cycle after ACCESS
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= (state == ACCESS);
      if (state == ACCESS) begin
        rsp_id    <= lat_id;
        rsp_err   <= !legal_c;
        rsp_rdata <= (legal_c && !lat_we) ? bus.m_rdata : 32'h0;
      end
    end
  end

  assign bus.c_gnt     = c_gnt_c;
  assign bus.a_gnt     = a_gnt_c;
  assign bus.m_rd_en   = m_rd_en_c;
  assign bus.m_wr_en   = m_wr_en_c;
  assign bus.m_addr    = lat_addr;
  assign bus.m_wdata   = lat_wdata;
  assign bus.m_func3   = lat_func3;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = rsp_id;
  assign bus.rsp_err   = rsp_err;
  assign bus.rsp_rdata = rsp_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural byte memory.
module tb_dmem_arbiter;

  typedef struct {
    bit          port;   // 0 = core, 1 = aux
    bit          we;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    bit          err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    bit          id;
    bit          err;
    logic [31:0] rdata;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;

  dmem_arbiter_if #(.ADDR_W(11)) bus ();

  dmem_arbiter #(.ADDR_W(11), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  rsp_t exp_q[$];
  vec_t vecs[21];
  bit   exp_win[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  // Byte memory: combinational read, negedge write
  logic [7:0] mem [0:2047];
  logic [7:0] b0, b1, b2, b3;

  always_comb begin
    b0 = mem[bus.m_addr];
    b1 = mem[bus.m_addr + 11'd1];
    b2 = mem[bus.m_addr + 11'd2];
    b3 = mem[bus.m_addr + 11'd3];
    case (bus.m_func3)
      3'b000:  bus.m_rdata = {{24{b0[7]}}, b0};
      3'b001:  bus.m_rdata = {{16{b1[7]}}, b1, b0};
      3'b010:  bus.m_rdata = {b3, b2, b1, b0};
      3'b100:  bus.m_rdata = {24'h0, b0};
      3'b101:  bus.m_rdata = {16'h0, b1, b0};
      default: bus.m_rdata = 32'h0;
    endcase
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    {mem[11'h013], mem[11'h012], mem[11'h011], mem[11'h010]} = 32'hDEADBEEF;
    {mem[11'h043], mem[11'h042], mem[11'h041], mem[11'h040]} = 32'h11223344;
    forever begin
      @(negedge clk);
      if (bus.m_wr_en === 1'b1) begin
        mem[bus.m_addr] = bus.m_wdata[7:0];
        if (bus.m_func3 != 3'b000) mem[bus.m_addr + 11'd1] = bus.m_wdata[15:8];
        if (bus.m_func3 == 3'b010) begin
          mem[bus.m_addr + 11'd2] = bus.m_wdata[23:16];
          mem[bus.m_addr + 11'd3] = bus.m_wdata[31:24];
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to the next negedge and score any response present there
  task automatic step();
    rsp_t e;
    @(negedge clk);
    if (bus.rsp_valid === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got id=%0d err=%0d rdata=%h expected no response",
                 bus.rsp_id, bus.rsp_err, bus.rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        if (bus.rsp_id !== e.id || bus.rsp_err !== e.err || bus.rsp_rdata !== e.rdata) begin
          n_fail++;
          $display("FAIL rsp: got id=%0d err=%0d rdata=%h expected id=%0d err=%0d rdata=%h",
                   bus.rsp_id, bus.rsp_err, bus.rsp_rdata, e.id, e.err, e.rdata);
        end
      end
    end
  endtask

  task automatic drive_req(input bit port, input bit req, input bit we,
                           input logic [10:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3);
    if (port) begin
      bus.a_req = req; bus.a_we = we; bus.a_addr = addr;
      bus.a_wdata = wdata; bus.a_func3 = f3;
    end else begin
      bus.c_req = req; bus.c_we = we; bus.c_addr = addr;
      bus.c_wdata = wdata; bus.c_func3 = f3;
    end
  endtask

  task automatic wait_gnt(input bit port, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if ((port ? bus.a_gnt : bus.c_gnt) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL gnt_timeout: got no grant for port %0d expected grant", port);
    end
  endtask

  // One single-requester transaction; response is scored by a later step()
  task automatic access(input vec_t v);
    bit   ok;
    rsp_t e;
    step();
    drive_req(v.port, 1'b1, v.we, v.addr, v.wdata, v.f3);
    wait_gnt(v.port, ok);
    if (ok) begin
      chk("other_gnt", 32'(v.port ? bus.c_gnt : bus.a_gnt), 32'h0);
      e = '{v.port, v.err, v.rdata};
      exp_q.push_back(e);
      step();
      chk("m_rd_en", 32'(bus.m_rd_en), 32'(!v.err && !v.we));
      chk("m_wr_en", 32'(bus.m_wr_en), 32'(!v.err && v.we));
      chk("m_addr", 32'(bus.m_addr), 32'(v.addr));
    end
    drive_req(v.port, 1'b0, 1'b0, 11'h0, 32'h0, 3'b000);
  endtask

  initial begin
    bit   ok, got;
    rsp_t e;
    vec_t v;

    //          port we addr     wdata         f3      err rdata
    vecs[0]  = '{0, 0, 11'h010, 32'h0,        3'b010, 0, 32'hDEADBEEF};
    vecs[1]  = '{0, 0, 11'h010, 32'h0,        3'b001, 0, 32'hFFFFBEEF};
    vecs[2]  = '{0, 0, 11'h012, 32'h0,        3'b101, 0, 32'h0000DEAD};
    vecs[3]  = '{0, 0, 11'h013, 32'h0,        3'b000, 0, 32'hFFFFFFDE};
    vecs[4]  = '{1, 1, 11'h020, 32'hCAFE5678, 3'b010, 0, 32'h0};
    vecs[5]  = '{1, 1, 11'h021, 32'h00001234, 3'b001, 1, 32'h0};
    vecs[6]  = '{1, 0, 11'h020, 32'h0,        3'b101, 0, 32'h00005678};
    vecs[7]  = '{0, 1, 11'h005, 32'h000000AB, 3'b000, 0, 32'h0};
    vecs[8]  = '{0, 0, 11'h005, 32'h0,        3'b000, 0, 32'hFFFFFFAB};
    vecs[9]  = '{0, 0, 11'h005, 32'h0,        3'b100, 0, 32'h000000AB};
    vecs[10] = '{0, 0, 11'h010, 32'h0,        3'b011, 1, 32'h0};
    vecs[11] = '{0, 0, 11'h012, 32'h0,        3'b010, 1, 32'h0};
    vecs[12] = '{1, 1, 11'h030, 32'h12345678, 3'b100, 1, 32'h0};
    vecs[13] = '{1, 0, 11'h020, 32'h0,        3'b010, 0, 32'hCAFE5678};
    vecs[14] = '{0, 1, 11'h022, 32'hFFFF1234, 3'b001, 0, 32'h0};
    vecs[15] = '{1, 0, 11'h020, 32'h0,        3'b010, 0, 32'h12345678};
    vecs[16] = '{0, 0, 11'h7FC, 32'h0,        3'b010, 0, 32'h0};
    vecs[17] = '{0, 0, 11'h7FF, 32'h0,        3'b001, 1, 32'h0};
    vecs[18] = '{1, 1, 11'h7FF, 32'h0000005A, 3'b000, 0, 32'h0};
    vecs[19] = '{1, 0, 11'h7FF, 32'h0,        3'b100, 0, 32'h0000005A};
    vecs[20] = '{0, 0, 11'h040, 32'h0,        3'b010, 0, 32'h11223344};

    rst = 1'b1;
    drive_req(1'b0, 1'b0, 1'b0, 11'h0, 32'h0, 3'b000);
    drive_req(1'b1, 1'b0, 1'b0, 11'h0, 32'h0, 3'b000);
    repeat (3) step();
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_gnt", 32'({bus.c_gnt, bus.a_gnt}), 32'h0);
    chk("rst_m_en", 32'({bus.m_rd_en, bus.m_wr_en}), 32'h0);
    chk("rst_m_addr", 32'(bus.m_addr), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) access(vecs[i]);

    // Both requesters held: aux forced through every fifth grant
    step();
    drive_req(1'b0, 1'b1, 1'b0, 11'h010, 32'h0, 3'b010);
    drive_req(1'b1, 1'b1, 1'b0, 11'h020, 32'h0, 3'b010);
    for (int g = 0; g < 10; g++) begin
      got = 1'b0;
      for (int k = 0; k < 4; k++) begin
        #1;
        if (bus.c_gnt === 1'b1 || bus.a_gnt === 1'b1) begin
          got = 1'b1;
          break;
        end
        step();
      end
      if (!got) begin
        n_tests++;
        n_fail++;
        $display("FAIL starve_gnt_timeout: got no grant at %0d expected grant", g);
      end else begin
        chk("starve_winner", 32'(bus.a_gnt), 32'(exp_win[g]));
        chk("starve_onehot", 32'(bus.c_gnt ^ bus.a_gnt), 32'h1);
        e = '{exp_win[g], 1'b0, exp_win[g] ? 32'h12345678 : 32'hDEADBEEF};
        exp_q.push_back(e);
      end
      step();
    end
    drive_req(1'b0, 1'b0, 1'b0, 11'h0, 32'h0, 3'b000);
    drive_req(1'b1, 1'b0, 1'b0, 11'h0, 32'h0, 3'b000);

    // Reset during ACCESS of a store: dropped, no write, no response
    step();
    drive_req(1'b0, 1'b1, 1'b1, 11'h040, 32'h55667788, 3'b010);
    wait_gnt(1'b0, ok);
    if (ok) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive_req(1'b0, 1'b0, 1'b0, 11'h0, 32'h0, 3'b000);
      step();
      chk("rstacc_m_wr_en", 32'(bus.m_wr_en), 32'h0);
      chk("rstacc_m_rd_en", 32'(bus.m_rd_en), 32'h0);
      @(posedge clk);
      #1;
      chk("rstacc_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("rstacc_rsp_id_err", 32'({bus.rsp_id, bus.rsp_err}), 32'h0);
      chk("rstacc_rsp_rdata", bus.rsp_rdata, 32'h0);
      chk("rstacc_m_addr", 32'(bus.m_addr), 32'h0);
      chk("rstacc_m_wdata", bus.m_wdata, 32'h0);
      chk("rstacc_m_func3", 32'(bus.m_func3), 32'h0);
      chk("rstacc_gnt", 32'({bus.c_gnt, bus.a_gnt}), 32'h0);
      rst = 1'b0;
    end else begin
      drive_req(1'b0, 1'b0, 1'b0, 11'h0, 32'h0, 3'b000);
    end
    v = vecs[20];
    access(v);

    step();
    step();
    step();
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
